// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ register-read requesters, with watchdog abort.
// Latency: request sampled in IDLE cycle N gives m_start at N+1; m_done at M gives resp_valid at M+1.
// Backpressure: requests are level-held until resp_valid; no grant while m_busy or while a transaction is open.
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 520000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_devaddr,
  input  logic [8*NREQ-1:0] req_regaddr,
  output logic [NREQ-1:0]   resp_valid,
  output logic [15:0]       resp_data,
  output logic              resp_err,
  output logic [1:0]        grant_id,
  output logic              m_start,
  output logic [6:0]        m_devaddr,
  output logic [7:0]        m_regaddr,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [15:0]       m_data,
  input  logic              m_nack
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // The timer holds cycles-since-m_start minus one, so expiring on the
  // incremented value makes resp_valid land exactly TIMEOUT cycles after m_start.
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT - 1);
  localparam logic [1:0]  LAST_IDX = 2'(NREQ - 1);

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [19:0] timer_q, timer_d;
  logic [1:0]  grant_q, grant_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  scan_idx;

  // Round-robin pick: scan from the farthest slot back to rr_ptr so the
  // nearest requesting index (starting at rr_ptr) is the last one written.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = 2'((int'(rr_ptr_q) + i) % NREQ);
      if (req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // FSM next-state and pulse outputs; latched values default to holding.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    grant_d    = grant_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    m_start    = 1'b0;
    resp_valid = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld && !m_busy) begin
          grant_d = pick_idx;
          dev_d   = req_devaddr[7*pick_idx +: 7];
          reg_d   = req_regaddr[8*pick_idx +: 8];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_start = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 20'd1;
        // A completion in the expiry cycle takes precedence over the abort.
        if (m_done) begin
          rdata_d = m_data;
          rerr_d  = m_nack;
          state_d = S_RESP;
        end else if (timer_d == TO_LAST) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[grant_q] = 1'b1;
        rr_ptr_d = (grant_q == LAST_IDX) ? 2'd0 : grant_q + 2'd1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched output registers; reset aborts any open transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      grant_q  <= '0;
      dev_q    <= '0;
      reg_q    <= '0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      timer_q  <= timer_d;
      grant_q  <= grant_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign grant_id  = grant_q;
  assign m_devaddr = dev_q;
  assign m_regaddr = reg_q;
  assign resp_data = rdata_q;
  assign resp_err  = rerr_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter with a short watchdog.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Master side is modelled by hand-placed m_done pulses.
module tb_i2c_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [7*NREQ-1:0] req_devaddr;
  logic [8*NREQ-1:0] req_regaddr;
  logic [NREQ-1:0]   resp_valid;
  logic [15:0]       resp_data;
  logic              resp_err;
  logic [1:0]        grant_id;
  logic              m_start;
  logic [6:0]        m_devaddr;
  logic [7:0]        m_regaddr;
  logic              m_busy;
  logic              m_done;
  logic [15:0]       m_data;
  logic              m_nack;

  int checks = 0;
  int errors = 0;
  int n;
  int exp_idx;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_devaddr(req_devaddr), .req_regaddr(req_regaddr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .grant_id(grant_id), .m_start(m_start), .m_devaddr(m_devaddr), .m_regaddr(m_regaddr),
    .m_busy(m_busy), .m_done(m_done), .m_data(m_data), .m_nack(m_nack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (m_start !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("start_seen", {31'd0, m_start}, 32'd1);
  endtask

  task automatic master_done(input logic [15:0] d, input logic nack);
    m_done = 1'b1;
    m_data = d;
    m_nack = nack;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, {28'd0, resp_valid}, 32'd0);
    check({tag, "_resp_data"},  {16'd0, resp_data},  32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
    check({tag, "_grant_id"},   {30'd0, grant_id},   32'd0);
    check({tag, "_m_start"},    {31'd0, m_start},    32'd0);
    check({tag, "_m_devaddr"},  {25'd0, m_devaddr},  32'd0);
    check({tag, "_m_regaddr"},  {24'd0, m_regaddr},  32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    m_busy    = 1'b0;
    m_done    = 1'b0;
    m_data    = '0;
    m_nack    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_devaddr[7*i +: 7] = 7'h48 + 7'(i);
      req_regaddr[8*i +: 8] = 8'(16 * i);
    end

    // Reset values
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // Single request from index 0
    req_valid = 4'b0001;
    tick();
    check("single_start",   {31'd0, m_start},   32'd1);
    check("single_devaddr", {25'd0, m_devaddr}, 32'h48);
    check("single_regaddr", {24'd0, m_regaddr}, 32'h00);
    check("single_grant",   {30'd0, grant_id},  32'd0);
    tick();
    check("single_start_one_cycle", {31'd0, m_start}, 32'd0);
    master_done(16'h1A80, 1'b0);
    check("single_resp_valid", {28'd0, resp_valid}, 32'b0001);
    check("single_resp_data",  {16'd0, resp_data},  32'h1A80);
    check("single_resp_err",   {31'd0, resp_err},   32'd0);
    req_valid = '0;
    tick();
    check("single_resp_pulse", {28'd0, resp_valid}, 32'd0);
    check("single_data_hold",  {16'd0, resp_data},  32'h1A80);

    // NACK from index 2 (rr_ptr now 1)
    req_valid = 4'b0100;
    tick();
    check("nack_start",   {31'd0, m_start},   32'd1);
    check("nack_grant",   {30'd0, grant_id},  32'd2);
    check("nack_devaddr", {25'd0, m_devaddr}, 32'h4A);
    check("nack_regaddr", {24'd0, m_regaddr}, 32'h20);
    tick();
    master_done(16'hFFFF, 1'b1);
    check("nack_resp_valid", {28'd0, resp_valid}, 32'b0100);
    check("nack_resp_err",   {31'd0, resp_err},   32'd1);
    check("nack_resp_data",  {16'd0, resp_data},  32'hFFFF);
    req_valid = '0;
    tick();

    // m_done while IDLE is ignored
    master_done(16'hDEAD, 1'b0);
    check("stray_done_resp", {28'd0, resp_valid}, 32'd0);
    check("stray_done_data", {16'd0, resp_data},  32'hFFFF);
    tick();
    check("stray_done_later", {28'd0, resp_valid}, 32'd0);

    // m_busy holds off the grant
    m_busy    = 1'b1;
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_no_start", {31'd0, m_start}, 32'd0);
    end
    m_busy = 1'b0;
    tick();
    check("busy_release_start", {31'd0, m_start},  32'd1);
    check("busy_release_grant", {30'd0, grant_id}, 32'd1);
    tick();
    master_done(16'h0042, 1'b0);
    check("busy_resp_valid", {28'd0, resp_valid}, 32'b0010);
    check("busy_resp_data",  {16'd0, resp_data},  32'h0042);
    check("busy_resp_err",   {31'd0, resp_err},   32'd0);
    req_valid = '0;
    tick();

    // Timeout on index 3: resp exactly TIMEOUT cycles after m_start
    req_valid = 4'b1000;
    tick();
    check("to_start", {31'd0, m_start},  32'd1);
    check("to_grant", {30'd0, grant_id}, 32'd3);
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid === 4'b0000 && n < 300);
    check("to_latency",    n,                      TIMEOUT);
    check("to_resp_valid", {28'd0, resp_valid},    32'b1000);
    check("to_resp_err",   {31'd0, resp_err},      32'd1);
    check("to_resp_data",  {16'd0, resp_data},     32'd0);
    req_valid = '0;
    tick();

    // m_done in the expiry cycle wins
    req_valid = 4'b0001;
    tick();
    check("race_start", {31'd0, m_start},  32'd1);
    check("race_grant", {30'd0, grant_id}, 32'd0);
    repeat (TIMEOUT - 1) tick();
    check("race_no_early_resp", {28'd0, resp_valid}, 32'd0);
    master_done(16'h1234, 1'b0);
    check("race_resp_valid", {28'd0, resp_valid}, 32'b0001);
    check("race_resp_err",   {31'd0, resp_err},   32'd0);
    check("race_resp_data",  {16'd0, resp_data},  32'h1234);
    req_valid = '0;
    tick();

    // Reset during WAIT
    req_valid = 4'b0100;
    tick();
    check("rstw_grant", {30'd0, grant_id}, 32'd2);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("rstw");
    tick();
    check("rstw_no_resp", {28'd0, resp_valid}, 32'd0);

    // All four held after reset: grants 0,1,2,3,0
    rst       = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_idx = k % NREQ;
      wait_start();
      check("rr_grant",   {30'd0, grant_id},  exp_idx);
      check("rr_devaddr", {25'd0, m_devaddr}, 32'h48 + exp_idx);
      tick();
      master_done(16'hA000 + 16'(k), 1'b0);
      check("rr_resp_valid", {28'd0, resp_valid}, 32'd1 << exp_idx);
      check("rr_resp_data",  {16'd0, resp_data},  32'hA000 + k);
    end
    req_valid = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
